poly_mem_arbiter: RTL and testbench
===================================

// Module: poly_mem_arbiter
// PURPOSE
//  Shares one single-port polynomial RAM among the key-generation engines (g, h0, h1, f/add units).
//  Per-requester req/gnt handshake; optional lock holds ownership for burst transfers.
//  Read data returns with per-requester valid strobes.
//  Sits between the generator engines and the polynomial BRAM, beside the top-level sequencing FSM.
// PARAMETERS
//  NREQ    4   number of requesters (index = requester id)
//  AW      10  RAM address width
//  DW      32  RAM data width
//  RD_LAT  1   RAM read latency in cycles (>=1)
// PORTS
//  clk        in   1         system clock, all logic on rising edge
//  rst        in   1         synchronous reset, active-high
//  req        in   NREQ      access request, one bit per requester
//  lock       in   NREQ      hold ownership after current access (burst)
//  we         in   NREQ      1 = write, 0 = read (qualified by req & gnt)
//  addr       in   NREQ*AW   flattened addresses, requester i at [i*AW +: AW]
//  wdata      in   NREQ*DW   flattened write data, requester i at [i*DW +: DW]
//  gnt        out  NREQ      one-hot ownership, registered
//  rvalid     out  NREQ      read data valid for requester i
//  rdata      out  DW        read data, broadcast; qualified by rvalid
//  mem_en     out  1         RAM enable
//  mem_we     out  1         RAM write enable
//  mem_addr   out  AW        RAM address
//  mem_wdata  out  DW        RAM write data
//  mem_rdata  in   DW        RAM read data, RD_LAT cycles after a read is issued
//  busy       out  1         1 while any requester owns the RAM
// BEHAVIOUR
//  Reset: gnt=0, rvalid=0, busy=0, mem_en=0, mem_we=0, owner=0, RR pointer=0, read pipe flushed.
//  FSM states:
//   IDLE: if |req, pick winner W, go to OWN with gnt=onehot(W) on the next cycle. Otherwise stay.
//   OWN:  owner O holds the grant.
//  Access rule: a RAM access is issued in any OWN cycle with req[O]=1.
//   mem_en=req[O], mem_we=req[O]&we[O], mem_addr/mem_wdata = slice O.
//   mem_* is combinational from the registered owner; mem_en=0 in IDLE.
//  End of each OWN cycle:
//   lock[O]=1: stay in OWN, same owner. lock without req idles the RAM but keeps the grant.
//   lock[O]=0: release. If any req is pending (including O), arbitrate that same cycle; the new
//    gnt appears next cycle with no idle bubble. Otherwise go to IDLE.
//   Net effect: an unlocked grant covers exactly one access cycle.
//  Requester may drop req while holding gnt: no access, grant follows the lock rule.
//  Reads: (issue & ~we, O) enters an RD_LAT-deep shift pipe.
//   rvalid[O] pulses exactly RD_LAT cycles after issue; rdata=mem_rdata in that cycle.
//   Back-to-back reads give back-to-back rvalid; writes produce no rvalid.
//  Reads in flight across an owner change still return to the issuing requester (tag travels in pipe).
//  busy = (state==OWN).
//  Reset mid-operation: grant dropped, pipe flushed, in-flight reads lost; requesters re-request.
//  Outputs for requester ids >= NREQ do not exist.
// CONFIGURATION
//  ARB_ROUND_ROBIN_EN defined: round-robin arbitration.
//   Pointer = (last owner + 1) mod NREQ; search upward from the pointer with wrap-around.
//   Pointer updates on each new grant.
//  ARB_ROUND_ROBIN_EN undefined: fixed priority, lowest index wins; no pointer register.
// STRUCTURE
//  Shared package (bike_kg_pkg): requester id constants REQ_G=0, REQ_H0=1, REQ_H1=2, REQ_F=3;
//   FSM state encodings.
//  Sub-module arb_pick: combinational winner select (req, ptr -> onehot, idx);
//   round-robin/fixed choice inside, controlled by the macro.
//  Top level holds the FSM, owner register, access mux and read-tag pipe.
// TESTING
//  1 Single read: req[1]=1, we=0, addr=0x005 -> gnt[1] on cycle+1, mem_en on cycle+1, rvalid[1]
//    on cycle+1+RD_LAT with rdata=RAM[5]; busy drops after the release.
//  2 Burst: req[2]&lock[2] for 8 writes to 0..7, req[0] asserted throughout -> gnt[2] held 8 cycles;
//    gnt[0] in the cycle after lock[2] falls, no bubble.
//  3 Contention: req=4'b1111 unlocked, held -> fixed: gnt[0] every grant.
//    RR: order 0,1,2,3,0 with one access each.
//  4 In-flight read across owner change, RD_LAT=2: read by id 3 then immediate grant to id 1 ->
//    rvalid[3] (not rvalid[1]) pulses 2 cycles after the issue.
//  5 Drop req under lock: id 0 holds lock, req=0 for 3 cycles -> mem_en=0, gnt[0] stays 1.
//  6 Reset mid-burst: rst=1 during a locked read burst -> next cycle gnt=0, rvalid=0, busy=0;
//    no stale rvalid after rst falls.

Source files
------------

// File: rtl/bike_kg_pkg.sv
// Shared constants for the key-generation datapath: requester ids and the
// polynomial RAM arbiter state encoding.
package bike_kg_pkg;

    localparam int unsigned REQ_G  = 0;
    localparam int unsigned REQ_H0 = 1;
    localparam int unsigned REQ_H1 = 2;
    localparam int unsigned REQ_F  = 3;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select for the polynomial RAM arbiter.
// ARB_ROUND_ROBIN_EN defined: search upward from ptr with wrap; otherwise lowest index wins.
module arb_pick #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] onehot,
    output logic [IW-1:0]   idx
);

    int unsigned start;
    int unsigned cand;
    logic        found;

`ifdef ARB_ROUND_ROBIN_EN
    assign start = 32'(ptr);
`else
    logic ptr_unused;
    assign ptr_unused = ^ptr;
    assign start      = 0;
`endif

    always_comb begin
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        cand   = 0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            cand = start + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!found && req[cand[IW-1:0]]) begin
                found = 1'b1;
                idx   = cand[IW-1:0];
            end
        end
        onehot[idx] = found;
    end

endmodule

// File: rtl/poly_mem_arbiter.sv
// Single-port polynomial RAM arbiter: req/gnt ownership FSM, optional lock bursts,
// tagged read-return pipe. ARB_ROUND_ROBIN_EN selects round-robin over fixed priority.
module poly_mem_arbiter
    import bike_kg_pkg::*;
#(
    parameter int unsigned NREQ   = 4,
    parameter int unsigned AW     = 10,
    parameter int unsigned DW     = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ-1:0]    lock,
    input  logic [NREQ-1:0]    we,
    input  logic [NREQ*AW-1:0] addr,
    input  logic [NREQ*DW-1:0] wdata,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    rvalid,
    output logic [DW-1:0]      rdata,
    output logic               mem_en,
    output logic               mem_we,
    output logic [AW-1:0]      mem_addr,
    output logic [DW-1:0]      mem_wdata,
    input  logic [DW-1:0]      mem_rdata,
    output logic               busy
);

    localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    arb_state_e      state, state_nxt;
    logic [IW-1:0]   owner, owner_nxt;
    logic [NREQ-1:0] gnt_nxt;
    logic [NREQ-1:0] pick_onehot;
    logic [IW-1:0]   pick_idx;
    logic [IW-1:0]   ptr;
    logic            take;
    logic [RD_LAT-1:0] pipe_v;
    logic [IW-1:0]     pipe_tag [RD_LAT];

    arb_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (req),
        .ptr    (ptr),
        .onehot (pick_onehot),
        .idx    (pick_idx)
    );

`ifdef ARB_ROUND_ROBIN_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr <= '0;
        end else if (take) begin
            ptr <= (pick_idx == IW'(NREQ - 1)) ? '0 : pick_idx + 1'b1;
        end
    end
`else
    assign ptr = '0;
`endif

    // Releasing owner re-arbitrates in the same cycle, so a new grant follows without a bubble.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        gnt_nxt   = gnt;
        take      = 1'b0;
        case (state)
            ST_IDLE: take = |req;
            ST_OWN: begin
                if (!lock[owner]) begin
                    if (|req) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                        gnt_nxt   = '0;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
        if (take) begin
            state_nxt = ST_OWN;
            owner_nxt = pick_idx;
            gnt_nxt   = pick_onehot;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
            owner <= IW'(REQ_G);
            gnt   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            gnt   <= gnt_nxt;
        end
    end

    assign mem_en    = (state == ST_OWN) && req[owner];
    assign mem_we    = mem_en && we[owner];
    assign mem_addr  = addr[owner*AW +: AW];
    assign mem_wdata = wdata[owner*DW +: DW];
    assign busy      = (state == ST_OWN);

    // Tag travels with each read so returns reach the issuer even after an owner change.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_v <= '0;
            for (int unsigned s = 0; s < RD_LAT; s++) begin
                pipe_tag[s] <= '0;
            end
        end else begin
            pipe_v[0]   <= mem_en && !mem_we;
            pipe_tag[0] <= owner;
            for (int unsigned s = 1; s < RD_LAT; s++) begin
                pipe_v[s]   <= pipe_v[s-1];
                pipe_tag[s] <= pipe_tag[s-1];
            end
        end
    end

    always_comb begin
        rvalid = '0;
        rvalid[pipe_tag[RD_LAT-1]] = pipe_v[RD_LAT-1];
    end

    assign rdata = mem_rdata;

endmodule

// File: tb/tb_poly_mem_arbiter.sv
// Scoreboard bench for poly_mem_arbiter with a behavioural RAM of latency RD_LAT;
// expectations track ARB_ROUND_ROBIN_EN where arbitration order differs.
`timescale 1ns/1ps
module tb_poly_mem_arbiter;

    localparam int unsigned NREQ   = 4;
    localparam int unsigned AW     = 10;
    localparam int unsigned DW     = 32;
    localparam int unsigned RD_LAT = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic [NREQ-1:0]    req, lock, we;
    logic [AW-1:0]      addr_a  [NREQ];
    logic [DW-1:0]      wdata_a [NREQ];
    logic [NREQ*AW-1:0] addr;
    logic [NREQ*DW-1:0] wdata;
    logic [NREQ-1:0]    gnt, rvalid;
    logic [DW-1:0]      rdata, mem_wdata, mem_rdata;
    logic               mem_en, mem_we, busy;
    logic [AW-1:0]      mem_addr;

    int unsigned checks = 0;
    int unsigned errors = 0;

    typedef struct {
        int unsigned id;
        logic [DW-1:0] data;
    } rd_t;
    rd_t sb [$];

    logic [DW-1:0] exp_mem [1 << AW];

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr[i*AW +: AW]  = addr_a[i];
            wdata[i*DW +: DW] = wdata_a[i];
        end
    end

    poly_mem_arbiter #(
        .NREQ   (NREQ),
        .AW     (AW),
        .DW     (DW),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .lock      (lock),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .gnt       (gnt),
        .rvalid    (rvalid),
        .rdata     (rdata),
        .mem_en    (mem_en),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata),
        .busy      (busy)
    );

    // Behavioural RAM: preloaded with A500_0000 | address on the first clock.
    logic [DW-1:0] ram     [1 << AW];
    logic [DW-1:0] rd_pipe [RD_LAT];
    logic          init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < (1 << AW); i++) ram[i] = 32'hA500_0000 | i;
            for (int i = 0; i < RD_LAT; i++) rd_pipe[i] <= '0;
            init_done <= 1'b1;
        end else begin
            if (mem_en === 1'b1 && mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
            rd_pipe[0] <= ram[mem_addr];
            for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
        end
    end
    assign mem_rdata = rd_pipe[RD_LAT-1];

    // Monitor: every rvalid must match the oldest outstanding read.
    initial begin
        rd_t e;
        logic [NREQ-1:0] exp_v;
        forever begin
            @(negedge clk);
            if (rvalid !== '0) begin
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL rvalid_unexpected: got rvalid=%b, required none", rvalid);
                end else begin
                    e = sb.pop_front();
                    exp_v = '0;
                    exp_v[e.id] = 1'b1;
                    if (rvalid !== exp_v || rdata !== e.data) begin
                        errors++;
                        $display("FAIL rd_return: got rvalid=%b rdata=%h, required rvalid=%b rdata=%h",
                                 rvalid, rdata, exp_v, e.data);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int unsigned id, input logic [AW-1:0] a);
        rd_t e;
        e.id   = id;
        e.data = exp_mem[a];
        sb.push_back(e);
    endtask

    task automatic clear_in();
        req  = '0;
        lock = '0;
        we   = '0;
        for (int i = 0; i < NREQ; i++) begin
            addr_a[i]  = '0;
            wdata_a[i] = '0;
        end
    endtask

    initial begin
        int unsigned exp_id;
        logic [3:0] oh;

        for (int i = 0; i < (1 << AW); i++) exp_mem[i] = 32'hA500_0000 | i;
        rst = 1'b1;
        clear_in();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_mem_we", mem_we, 1'b0);
        chk("rst_rvalid", rvalid, 4'b0000);

        // Single read by id 1
        req = 4'b0010; addr_a[1] = 10'h005; #1;
        chk("t1_idle_mem_en", mem_en, 1'b0);
        chk("t1_idle_gnt", gnt, 4'b0000);
        tick();
        chk("t1_gnt", gnt, 4'b0010);
        chk("t1_mem_en", mem_en, 1'b1);
        chk("t1_mem_we", mem_we, 1'b0);
        chk("t1_mem_addr", mem_addr, 10'h005);
        chk("t1_busy", busy, 1'b1);
        push(1, 10'h005);
        tick();
        req = '0; #1;
        chk("t1_regrant_gnt", gnt, 4'b0010);
        chk("t1_regrant_mem_en", mem_en, 1'b0);
        tick();
        chk("t1_release_busy", busy, 1'b0);
        chk("t1_release_gnt", gnt, 4'b0000);

        // Locked burst of 8 writes by id 2 with id 0 waiting
        req = 4'b0100; lock = 4'b0100; we = 4'b0100; #1;
        tick();
        for (int i = 0; i < 8; i++) begin
            req = 4'b0101; we = 4'b0100;
            addr_a[2]  = 10'(i);
            wdata_a[2] = 32'hC0DE_0000 + i;
            lock = (i < 7) ? 4'b0100 : 4'b0000;
            #1;
            chk("t2_burst_gnt", gnt, 4'b0100);
            chk("t2_burst_mem_we", mem_we, 1'b1);
            chk("t2_burst_addr", mem_addr, 10'(i));
            chk("t2_burst_wdata", mem_wdata, 32'hC0DE_0000 + i);
            exp_mem[i] = 32'hC0DE_0000 + i;
            tick();
        end
        req = 4'b0001; lock = '0; we = '0; addr_a[0] = 10'h003; #1;
        chk("t2_no_bubble_gnt", gnt, 4'b0001);
        chk("t2_follow_mem_en", mem_en, 1'b1);
        chk("t2_follow_addr", mem_addr, 10'h003);
        push(0, 10'h003);
        tick();
        req = '0; #1;
        chk("t2_idle_mem_en", mem_en, 1'b0);
        tick();
        chk("t2_release_busy", busy, 1'b0);

        // Reset so the round-robin pointer starts at 0, then full contention
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        chk("t3_rst_busy", busy, 1'b0);
        req = 4'b1111; we = '0;
        for (int i = 0; i < NREQ; i++) addr_a[i] = 10'h010 + 10'(i);
        #1;
        tick();
        for (int n = 0; n < 5; n++) begin
`ifdef ARB_ROUND_ROBIN_EN
            exp_id = n % NREQ;
`else
            exp_id = 0;
`endif
            oh = '0;
            oh[exp_id] = 1'b1;
            chk("t3_contend_gnt", gnt, oh);
            chk("t3_contend_addr", mem_addr, 10'h010 + 10'(exp_id));
            push(exp_id, 10'h010 + 10'(exp_id));
            tick();
        end
        req = '0; #1;
        chk("t3_drop_mem_en", mem_en, 1'b0);
        tick();
        chk("t3_release_busy", busy, 1'b0);

        // Read by id 3 still in flight when id 1 takes the grant
        clear_in();
        req = 4'b1000; addr_a[3] = 10'h030; addr_a[1] = 10'h031; wdata_a[1] = 32'h1111_2222; #1;
        tick();
        req = 4'b1010; we = 4'b0010; #1;
        chk("t4_gnt3", gnt, 4'b1000);
        chk("t4_rd_mem_we", mem_we, 1'b0);
        chk("t4_rd_addr", mem_addr, 10'h030);
        push(3, 10'h030);
        tick();
        req = 4'b0010; #1;
        chk("t4_new_owner", gnt, 4'b0010);
        chk("t4_wr_mem_we", mem_we, 1'b1);
        chk("t4_wr_addr", mem_addr, 10'h031);
        exp_mem[10'h031] = 32'h1111_2222;
        tick();
        req = '0; #1;
        chk("t4_tag_rvalid", rvalid, 4'b1000);
        tick();
        chk("t4_release_busy", busy, 1'b0);

        // Locked owner drops req for 3 cycles
        clear_in();
        req = 4'b0001; lock = 4'b0001; addr_a[0] = 10'h050; #1;
        tick();
        chk("t5_gnt", gnt, 4'b0001);
        chk("t5_mem_en", mem_en, 1'b1);
        push(0, 10'h050);
        tick();
        for (int n = 0; n < 3; n++) begin
            req = '0; #1;
            chk("t5_hold_mem_en", mem_en, 1'b0);
            chk("t5_hold_gnt", gnt, 4'b0001);
            tick();
        end
        lock = '0; #1;
        chk("t5_unlock_gnt", gnt, 4'b0001);
        tick();
        chk("t5_release_busy", busy, 1'b0);
        chk("t5_release_gnt", gnt, 4'b0000);

        // Reset during a locked read burst: reads issued in the last two cycles are lost
        clear_in();
        req = 4'b0100; lock = 4'b0100; addr_a[2] = 10'h060; #1;
        tick();
        for (int k = 0; k < 4; k++) begin
            addr_a[2] = 10'h060 + 10'(k);
            if (k == 3) rst = 1'b1;
            #1;
            chk("t6_burst_addr", mem_addr, 10'h060 + 10'(k));
            if (k < 2) push(2, 10'h060 + 10'(k));
            tick();
        end
        chk("t6_rst_gnt", gnt, 4'b0000);
        chk("t6_rst_rvalid", rvalid, 4'b0000);
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_mem_en", mem_en, 1'b0);
        rst = 1'b0;
        clear_in();
        for (int n = 0; n < 4; n++) begin
            tick();
            chk("t6_no_stale_rvalid", rvalid, 4'b0000);
        end

        tick();
        chk("sb_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
